// File: rtl/hall_pkg.sv
// Shared hall-sensor types and decode helpers, also used by the commutation table block.
package hall_pkg;

   localparam int NUM_SECTORS = 6;

   typedef logic [2:0] sector_t;
   typedef logic [2:0] hall_code_t;

   typedef struct packed {
      logic    valid;
      sector_t sector;
   } hall_dec_t;

   // Classification of one accepted hall-code change.
   typedef enum logic [2:0] {
      EV_NONE,
      EV_ACQUIRE,
      EV_STEP,
      EV_INVALID,
      EV_SKIP
   } accept_ev_t;

   // {C,B,A} -> sector; 000 and 111 never occur on a healthy 120-degree sensor set.
   function automatic hall_dec_t hall_to_sector(input hall_code_t code);
      hall_dec_t d;
      d = '{valid: 1'b1, sector: 3'd0};
      case (code)
         3'b001:  d.sector = 3'd0;
         3'b011:  d.sector = 3'd1;
         3'b010:  d.sector = 3'd2;
         3'b110:  d.sector = 3'd3;
         3'b100:  d.sector = 3'd4;
         3'b101:  d.sector = 3'd5;
         default: d.valid  = 1'b0;
      endcase
      return d;
   endfunction

   // (to - from) mod NUM_SECTORS for sectors already in 0..5.
   function automatic sector_t sector_delta(input sector_t to, input sector_t from);
      logic [3:0] d;
      d = {1'b0, to} + 4'(NUM_SECTORS) - {1'b0, from};
      if (d >= 4'(NUM_SECTORS)) d = d - 4'(NUM_SECTORS);
      return d[2:0];
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// Synchronises the raw hall inputs and accepts a new code once it has been stable long enough.
module hall_debounce
   import hall_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] hs_in,
   output logic [2:0] accept_code,
   output logic       accept
);

   localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_REQ = CNT_W'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   hall_code_t                  sync_out;
   hall_code_t                  prev;
   hall_code_t                  code;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            run;

   assign sync_out    = sync_q[SYNC_STAGES-1];
   assign accept_code = sync_out;

   // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      run = CNT_ONE;
      if (sync_out == prev) run = cnt + CNT_ONE;
      // NOTE: the strobe is combinational so the consumer registers the new code on the same edge as this block.
      accept = (sync_out != code) && (run >= RUN_REQ);
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev   <= '0;
         code   <= '0;
         cnt    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hs_in};
         prev   <= sync_out;
         if ((sync_out == code) || accept) cnt <= '0;
         else                               cnt <= run;
         if (accept) code <= sync_out;
      end
   end

endmodule

// File: rtl/hall_decoder.sv
// Hall-sensor receive path: accepted code -> sector, direction, step period and stall/fault flags.
module hall_decoder
   import hall_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270,
   parameter int PERIOD_W        = 24,
   parameter int TIMEOUT_CYCLES  = 2700000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          hs_in,
   output logic [2:0]          sector,
   output logic                sector_valid,
   output logic                dir,
   output logic                step_pulse,
   output logic                hall_err,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                stalled
);

   // The timer is wide enough for both the period range and the stall threshold.
   localparam int                 TO_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam int                 TIMER_W    = (TO_W > PERIOD_W) ? TO_W : PERIOD_W;
   localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] STALL_AT   = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] PERIOD_MAX = TIMER_W'({PERIOD_W{1'b1}});

   logic         accept;
   hall_code_t   accept_code;
   hall_dec_t    dec;
   sector_t      delta;
   accept_ev_t   ev;
   logic         step_dir;
   logic         have_step;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_inc;
   logic [TIMER_W-1:0] period_next;

   hall_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .hs_in      (hs_in),
      .accept_code(accept_code),
      .accept     (accept)
   );

   assign dec   = hall_to_sector(accept_code);
   assign delta = sector_delta(dec.sector, sector);

   always_comb begin
      ev       = EV_NONE;
      step_dir = dir;
      if (accept) begin
         if (!dec.valid)            ev = EV_INVALID;
         else if (!sector_valid)    ev = EV_ACQUIRE;
         else if (delta == 3'd1) begin
            ev       = EV_STEP;
            step_dir = 1'b1;
         end else if (delta == 3'd5) begin
            ev       = EV_STEP;
            step_dir = 1'b0;
         end else                   ev = EV_SKIP;
      end
   end

   assign timer_inc   = (timer == TIMER_MAX) ? timer : timer + TIMER_ONE;
   assign period_next = (timer >= PERIOD_MAX) ? PERIOD_MAX : timer + TIMER_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         sector       <= '0;
         sector_valid <= 1'b0;
         dir          <= 1'b1;
         step_pulse   <= 1'b0;
         hall_err     <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         stalled      <= 1'b1;
         have_step    <= 1'b0;
         timer        <= '0;
      end else begin
         step_pulse <= 1'b0;
         hall_err   <= 1'b0;
         timer      <= timer_inc;

         // A step in the threshold cycle wins: the STEP branch below overrides these.
         if (timer >= STALL_AT) begin
            stalled      <= 1'b1;
            period_valid <= 1'b0;
            have_step    <= 1'b0;
         end

         case (ev)
            EV_INVALID: begin
               hall_err     <= 1'b1;
               sector_valid <= 1'b0;
               period_valid <= 1'b0;
               have_step    <= 1'b0;
               timer        <= '0;
            end
            EV_ACQUIRE: begin
               sector       <= dec.sector;
               sector_valid <= 1'b1;
               have_step    <= 1'b0;
            end
            EV_STEP: begin
               sector       <= dec.sector;
               dir          <= step_dir;
               step_pulse   <= 1'b1;
               period       <= period_next[PERIOD_W-1:0];
               period_valid <= have_step && (step_dir == dir) && !stalled;
               have_step    <= 1'b1;
               stalled      <= 1'b0;
               timer        <= '0;
            end
            EV_SKIP: begin
               sector       <= dec.sector;
               hall_err     <= 1'b1;
               period_valid <= 1'b0;
               have_step    <= 1'b0;
               timer        <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
